// File: rtl/mult16_pkg.sv
// ---------------------------------------------------------------------------
// mult16_pkg
// Shared definitions for the slices of the partitioned 16x16 multiplier.
//
// Contents:
//   SLICE_IN_W / SLICE_OUT_W : widths of one slice's input and output vectors
//   slice_in_t / slice_out_t : flat input and output vector types
//   slice_operands_t         : named view of the 7 slice inputs {a, b, c, cin},
//                              packed MSB-first in the same order as pi6..pi0
//   to_operands()            : reinterprets a flat input vector as operands
//   full_add()               : one-bit full adder, returns {carry, sum}
//   half_add()               : one-bit half adder, returns {carry, sum}
// ---------------------------------------------------------------------------
package mult16_pkg;

    localparam int SLICE_IN_W  = 7;
    localparam int SLICE_OUT_W = 4;

    // Operand widths inside one slice: 2x2 multiply plus a 2-bit addend.
    localparam int OPND_W = 2;

    typedef logic [SLICE_IN_W-1:0]  slice_in_t;
    typedef logic [SLICE_OUT_W-1:0] slice_out_t;

    // Field order matches the pin order pi6..pi0, so a plain cast works.
    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic [OPND_W-1:0] c;
        logic              cin;
    } slice_operands_t;

    function automatic slice_operands_t to_operands(input slice_in_t vec);
        return slice_operands_t'(vec);
    endfunction

    // Plain gate-level adders, kept as XOR/AND/OR so that an X on one
    // input only spreads to the bits that actually depend on it.
    function automatic logic [1:0] full_add(input logic x,
                                            input logic y,
                                            input logic ci);
        logic s;
        logic co;
        s  = x ^ y ^ ci;
        co = (x & y) | (x & ci) | (y & ci);
        return {co, s};
    endfunction

    function automatic logic [1:0] half_add(input logic x,
                                            input logic y);
        return {x & y, x ^ y};
    endfunction

endpackage

// File: rtl/mult2x2_cell.sv
// ---------------------------------------------------------------------------
// mult2x2_cell
// Combinational 2x2 unsigned multiplier producing a 4-bit product.
// Built from four AND-gate partial products and two half adders.
//
// Ports:
//   a [1:0] in  : multiplicand
//   b [1:0] in  : multiplier
//   p [3:0] out : product a*b (maximum 9)
// ---------------------------------------------------------------------------
module mult2x2_cell
    import mult16_pkg::*;
(
    input  logic [OPND_W-1:0]      a,
    input  logic [OPND_W-1:0]      b,
    output logic [SLICE_OUT_W-1:0] p
);

    logic       pp00;
    logic       pp10;
    logic       pp01;
    logic       pp11;
    logic [1:0] ha_col1;
    logic [1:0] ha_col2;

    // Partial products: ppXY = a[X] & b[Y].
    // Column 1 sums the two middle partial products; its carry joins
    // a[1]&b[1] in column 2, and that half adder's carry is bit 3.
    always_comb begin
        pp00    = a[0] & b[0];
        pp10    = a[1] & b[0];
        pp01    = a[0] & b[1];
        pp11    = a[1] & b[1];
        ha_col1 = half_add(pp10, pp01);
        ha_col2 = half_add(pp11, ha_col1[1]);
        p       = {ha_col2[1], ha_col2[0], ha_col1[0], pp00};
    end

endmodule

// File: rtl/mult16_3_slice.sv
// ---------------------------------------------------------------------------
// mult16_3_slice
// Registered 7-input / 4-output slice of the partitioned 16x16 multiplier.
// Computes sum = a*b + c + cin on 2-bit unsigned operands (max 13, so the
// 4-bit result never overflows) and presents it one clock later.
//
// Parameters:
//   REGISTER_OUT : 1 = output registered (1-cycle latency, reset active)
//                  0 = output combinational, clk and rst_n unused
//
// Ports:
//   clk        in  : system clock, rising edge
//   rst_n      in  : synchronous active-low reset, clears the output register
//   pi6, pi5   in  : a[1], a[0]   multiplicand
//   pi4, pi3   in  : b[1], b[0]   multiplier
//   pi2, pi1   in  : c[1], c[0]   addend
//   pi0        in  : cin          carry-in
//   po3..po0   out : sum[3..0]
// ---------------------------------------------------------------------------
module mult16_3_slice
    import mult16_pkg::*;
#(
    parameter int REGISTER_OUT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pi6,
    input  logic pi5,
    input  logic pi4,
    input  logic pi3,
    input  logic pi2,
    input  logic pi1,
    input  logic pi0,
    output logic po3,
    output logic po2,
    output logic po1,
    output logic po0
);

    slice_in_t       pi_vec;
    slice_operands_t ops;
    slice_out_t      product;
    slice_out_t      addend;
    slice_out_t      sum_comb;
    slice_out_t      po_vec;

    assign pi_vec = {pi6, pi5, pi4, pi3, pi2, pi1, pi0};
    assign ops    = to_operands(pi_vec);

    mult2x2_cell u_mult2x2_cell (
        .a (ops.a),
        .b (ops.b),
        .p (product)
    );

    assign addend = {{(SLICE_OUT_W-OPND_W){1'b0}}, ops.c};

    // Ripple-carry adder: product + addend + cin. The carry out of the top
    // bit is always zero for legal inputs, so it is simply not kept.
    always_comb begin
        logic       carry;
        logic [1:0] fa;
        carry    = ops.cin;
        sum_comb = '0;
        for (int i = 0; i < SLICE_OUT_W; i++) begin
            fa          = full_add(product[i], addend[i], carry);
            sum_comb[i] = fa[0];
            carry       = fa[1];
        end
    end

    generate
        if (REGISTER_OUT != 0) begin : g_reg
            slice_out_t po_d;
            slice_out_t po_q;

            always_comb begin
                po_d = sum_comb;
            end

            // Reset wins over the data so a result pending during reset
            // is dropped rather than emerging afterwards.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    po_q <= '0;
                end else begin
                    po_q <= po_d;
                end
            end

            assign po_vec = po_q;
        end else begin : g_comb
            assign po_vec = sum_comb;
        end
    endgenerate

    assign {po3, po2, po1, po0} = po_vec;

endmodule

// File: tb/tb_mult16_3_slice.sv
// ---------------------------------------------------------------------------
// tb_mult16_3_slice
// Self-checking bench for mult16_3_slice with REGISTER_OUT=1. Expected
// results are pushed to a queue as each vector is driven and popped when
// the registered output is sampled one edge later.
// ---------------------------------------------------------------------------
module tb_mult16_3_slice;

    logic       clk;
    logic       rst_n;
    logic [6:0] pi;
    logic       po3;
    logic       po2;
    logic       po1;
    logic       po0;
    logic [3:0] po_obs;

    int errors;
    int checks;

    logic [3:0] exp_q[$];

    assign po_obs = {po3, po2, po1, po0};

    mult16_3_slice #(.REGISTER_OUT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pi6   (pi[6]),
        .pi5   (pi[5]),
        .pi4   (pi[4]),
        .pi3   (pi[3]),
        .pi2   (pi[2]),
        .pi1   (pi[1]),
        .pi0   (pi[0]),
        .po3   (po3),
        .po2   (po2),
        .po1   (po1),
        .po0   (po0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent arithmetic model of the slice.
    function automatic logic [3:0] model(input logic [6:0] v);
        int a;
        int b;
        int c;
        int cin;
        a   = int'(v[6:5]);
        b   = int'(v[4:3]);
        c   = int'(v[2:1]);
        cin = int'(v[0]);
        return 4'(a * b + c + cin);
    endfunction

    // Drives one vector for one edge, pushing what the output must be
    // after that edge, then samples 1 time unit past the edge.
    task automatic drive(input logic [6:0] v, input logic r);
        pi    = v;
        rst_n = r;
        exp_q.push_back(r ? model(v) : 4'b0000);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] e;
        for (int k = 0; k < 2; k++) begin
            drive(7'b1111111, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (po_obs !== e || e !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL reset_hold[%0d] got=%b want=%b", k, po_obs, 4'b0000);
            end
        end
        drive(7'b1111111, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if (po_obs !== e || e !== 4'b1101) begin
            errors++;
            $display("[TB] FAIL reset_release got=%b want=%b", po_obs, 4'b1101);
        end
    endtask

    task automatic test_directed();
        logic [6:0] vecs [4];
        logic [3:0] want [4];
        string      names[4];
        logic [3:0] e;
        vecs[0] = 7'b0000000; want[0] = 4'b0000; names[0] = "zero";
        vecs[1] = 7'b1010000; want[1] = 4'b0100; names[1] = "product_only";
        vecs[2] = 7'b0000111; want[2] = 4'b0100; names[2] = "addend_only";
        vecs[3] = 7'b1111111; want[3] = 4'b1101; names[3] = "max";
        for (int k = 0; k < 4; k++) begin
            drive(vecs[k], 1'b1);
            e = exp_q.pop_front();
            checks++;
            if (po_obs !== e || e !== want[k]) begin
                errors++;
                $display("[TB] FAIL %s got=%b want=%b", names[k], po_obs, want[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e;
        for (int v = 0; v < 128; v++) begin
            drive(7'(v), 1'b1);
            e = exp_q.pop_front();
            checks++;
            if (po_obs !== e) begin
                errors++;
                $display("[TB] FAIL exhaustive[%0d] got=%b want=%b", v, po_obs, e);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [3:0] e;
        for (int v = 0; v < 128; v++) begin
            drive(7'(v), (v == 64) ? 1'b0 : 1'b1);
            e = exp_q.pop_front();
            checks++;
            if (po_obs !== e) begin
                errors++;
                $display("[TB] FAIL mid_reset[%0d] got=%b want=%b", v, po_obs, e);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        pi     = 7'b0000000;
        rst_n  = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_stream();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain got=%0d want=%0d", exp_q.size(), 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
